// File: rtl/cnt_readout_gen_pkg.sv
// Shared types and constants for the counter readout generator and its
// serializer-facing neighbours.
package cnt_readout_gen_pkg;

  // Readout frame states; the encoding is visible on the state_dbg port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_e;

  // Default framing words of the original 10-bit readout.
  localparam logic [9:0] CNT_HDR_DEF = 10'h234;
  localparam logic [9:0] CNT_TRL_DEF = 10'h2BF;

  // Legacy 52 x 10 bank layout, kept for the compatibility wrappers.
  typedef logic [51:0][9:0] a52x10_t;

endpackage

// File: rtl/cnt_readout_gen_inc_edge_sync.sv
// Two-flop synchroniser followed by a previous-value flop.
// The rise output is a single clk-cycle pulse marking a rising edge of
// async_in. async_in must stay high for at least two clk cycles.
module inc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Shift the asynchronous level through s1/s2 and keep one delayed copy in s3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/cnt_readout_gen.sv
// Counter readout generator: presents HEADER while idle, then one counter
// word per rising edge of increment, then TRAILER.
// Optional build macro: CNT_READOUT_SNAPSHOT_EN -- when defined, the whole
// counter bank is captured when a frame starts, so words 1..NUM_WORDS-1 come
// from a frame-coherent snapshot instead of the live bank.
//
// Handshake: increment is a level from the serializer; only its
// synchronised rising edge is a request. Each accepted request advances
// cnt_out and raises word_valid for exactly one clk50 cycle alongside the new
// value. There is no back-pressure; a request in DONE is refused and flagged
// through the sticky overrun bit. clr_rdout takes priority over a request
// arriving in the same cycle, and that request is dropped.
module cnt_readout_gen
  import cnt_readout_gen_pkg::*;
#(
  parameter int                WORD_W    = 10,
  parameter int                NUM_WORDS = 52,
  parameter logic [WORD_W-1:0] HEADER    = WORD_W'(CNT_HDR_DEF),
  parameter logic [WORD_W-1:0] TRAILER   = WORD_W'(CNT_TRL_DEF),
  localparam int               IDX_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk50,
  input  logic                        rst,
  input  logic                        clr_rdout,
  input  logic                        increment,
  input  logic [NUM_WORDS*WORD_W-1:0] words_in,
  output logic [WORD_W-1:0]           cnt_out,
  output logic                        word_valid,
  output logic                        rdout_done,
  output logic                        busy,
  output logic                        overrun,
  output logic [IDX_W-1:0]            word_idx,
  output cnt_state_e                  state_dbg
);

  // Word tables are padded to a power of two so word_idx indexes them directly.
  localparam int TBL_N = 2 ** IDX_W;

  cnt_state_e        state;
  logic              inc_rise;
  logic              frame_start;
  logic [WORD_W-1:0] live_w [TBL_N];
  logic [WORD_W-1:0] src_w  [TBL_N];

  inc_edge_sync u_inc_sync (
    .clk      (clk50),
    .rst      (rst),
    .async_in (increment),
    .rise     (inc_rise)
  );

  assign frame_start = inc_rise && !clr_rdout && (state == ST_IDLE);

  for (genvar k = 0; k < TBL_N; k++) begin : g_live
    if (k < NUM_WORDS) begin : g_word
      assign live_w[k] = words_in[k*WORD_W +: WORD_W];
    end else begin : g_pad
      assign live_w[k] = '0;
    end
  end

`ifdef CNT_READOUT_SNAPSHOT_EN
  logic [NUM_WORDS*WORD_W-1:0] shadow_q;

  // Capture the whole bank when a frame starts; word 0 is taken live that cycle.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (frame_start) begin
      shadow_q <= words_in;
    end
  end

  for (genvar k = 0; k < TBL_N; k++) begin : g_src
    if (k < NUM_WORDS) begin : g_word
      assign src_w[k] = shadow_q[k*WORD_W +: WORD_W];
    end else begin : g_pad
      assign src_w[k] = '0;
    end
  end
`else
  assign src_w = live_w;
`endif

  assign state_dbg = state;

  // Frame state machine; every output is registered here.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt_out    <= HEADER;
      word_idx   <= '0;
      word_valid <= 1'b0;
      rdout_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr_rdout) begin
        state      <= ST_IDLE;
        cnt_out    <= HEADER;
        word_idx   <= '0;
        rdout_done <= 1'b0;
        busy       <= 1'b0;
        overrun    <= 1'b0;
      end else if (inc_rise) begin
        case (state)
          ST_IDLE: begin
            cnt_out    <= live_w[0];
            word_idx   <= IDX_W'(1);
            busy       <= 1'b1;
            word_valid <= 1'b1;
            state      <= ST_SEND;
          end
          ST_SEND: begin
            word_valid <= 1'b1;
            if (word_idx == IDX_W'(NUM_WORDS)) begin
              // Trailer only after the last word has been presented for a full request.
              cnt_out    <= TRAILER;
              word_idx   <= '0;
              busy       <= 1'b0;
              rdout_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              cnt_out  <= src_w[word_idx];
              word_idx <= word_idx + IDX_W'(1);
            end
          end
          ST_DONE: begin
            overrun <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnt_readout_gen.sv
// Directed bench for cnt_readout_gen: default 52x10 instance plus a
// WORD_W=16 / NUM_WORDS=4 instance.
module tb_cnt_readout_gen;
  import cnt_readout_gen_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  always #10 clk50 = ~clk50;

  // ---------------- default instance ----------------
  logic          clr_rdout = 1'b0;
  logic          increment = 1'b0;
  logic [519:0]  words_in  = '0;
  logic [9:0]    cnt_out;
  logic          word_valid;
  logic          rdout_done;
  logic          busy;
  logic          overrun;
  logic [5:0]    word_idx;
  cnt_state_e    state_dbg;

  cnt_readout_gen dut (
    .clk50      (clk50),
    .rst        (rst),
    .clr_rdout  (clr_rdout),
    .increment  (increment),
    .words_in   (words_in),
    .cnt_out    (cnt_out),
    .word_valid (word_valid),
    .rdout_done (rdout_done),
    .busy       (busy),
    .overrun    (overrun),
    .word_idx   (word_idx),
    .state_dbg  (state_dbg)
  );

  // ---------------- 16-bit x 4 instance ----------------
  logic          clr2 = 1'b0;
  logic          inc2 = 1'b0;
  logic [63:0]   words2 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  logic [15:0]   cnt2;
  logic          valid2;
  logic          done2;
  logic          busy2;
  logic          ovr2;
  logic [2:0]    idx2;
  cnt_state_e    st2;

  cnt_readout_gen #(
    .WORD_W    (16),
    .NUM_WORDS (4),
    .HEADER    (16'hA5A5),
    .TRAILER   (16'h5A5A)
  ) dut2 (
    .clk50      (clk50),
    .rst        (rst),
    .clr_rdout  (clr2),
    .increment  (inc2),
    .words_in   (words2),
    .cnt_out    (cnt2),
    .word_valid (valid2),
    .rdout_done (done2),
    .busy       (busy2),
    .overrun    (ovr2),
    .word_idx   (idx2),
    .state_dbg  (st2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_valid2 = 0;
  logic [15:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk50) begin
    if (word_valid) n_valid++;
    if (valid2)     n_valid2++;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_inc();
    @(negedge clk50) increment = 1'b1;
    repeat (4) @(negedge clk50);
    increment = 1'b0;
    repeat (4) @(negedge clk50);
  endtask

  task automatic pulse_inc2();
    @(negedge clk50) inc2 = 1'b1;
    repeat (4) @(negedge clk50);
    inc2 = 1'b0;
    repeat (4) @(negedge clk50);
  endtask

  task automatic pulse_clr();
    @(negedge clk50) clr_rdout = 1'b1;
    @(negedge clk50) clr_rdout = 1'b0;
  endtask

  task automatic load_bank(input int base);
    for (int k = 0; k < 52; k++) words_in[k*10 +: 10] = 10'(base + k);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vsnap;
    logic [15:0] exp_w;

    load_bank(1);
    repeat (3) @(negedge clk50);
    rst = 1'b0;
    @(negedge clk50);

    // Reset state
    check_val("rst_cnt_out",  32'(cnt_out),    32'h234);
    check_val("rst_idx",      32'(word_idx),   32'd0);
    check_val("rst_valid",    32'(word_valid), 32'd0);
    check_val("rst_done",     32'(rdout_done), 32'd0);
    check_val("rst_busy",     32'(busy),       32'd0);
    check_val("rst_overrun",  32'(overrun),    32'd0);
    check_val("rst_state",    32'(state_dbg),  32'(ST_IDLE));
    check_val("rst_cnt2",     32'(cnt2),       32'hA5A5);

    // Full frame: 52 words k+1
    for (int i = 0; i < 52; i++) exp_q.push_back(16'(i + 1));
    for (int i = 0; i < 52; i++) begin
      pulse_inc();
      exp_w = exp_q.pop_front();
      check_val($sformatf("frame_word%0d", i), 32'(cnt_out), 32'(exp_w));
    end
    check_val("frame_valid_cnt", 32'(n_valid),    32'd52);
    check_val("frame_done_lo",   32'(rdout_done), 32'd0);
    check_val("frame_busy",      32'(busy),       32'd1);
    check_val("frame_idx_full",  32'(word_idx),   32'd52);
    check_val("frame_state",     32'(state_dbg),  32'(ST_SEND));
    pulse_inc();
    check_val("trl_cnt_out", 32'(cnt_out),    32'h2BF);
    check_val("trl_done",    32'(rdout_done), 32'd1);
    check_val("trl_busy",    32'(busy),       32'd0);
    check_val("trl_idx",     32'(word_idx),   32'd0);
    check_val("trl_valid",   32'(n_valid),    32'd53);

    // Overrun in DONE
    pulse_inc();
    pulse_inc();
    check_val("ovr_flag",    32'(overrun),   32'd1);
    check_val("ovr_cnt_out", 32'(cnt_out),   32'h2BF);
    check_val("ovr_novalid", 32'(n_valid),   32'd53);
    check_val("ovr_state",   32'(state_dbg), 32'(ST_DONE));
    pulse_clr();
    check_val("clr_cnt_out", 32'(cnt_out),    32'h234);
    check_val("clr_overrun", 32'(overrun),    32'd0);
    check_val("clr_done",    32'(rdout_done), 32'd0);
    check_val("clr_state",   32'(state_dbg),  32'(ST_IDLE));

    // Abort after the 10th word
    repeat (10) pulse_inc();
    check_val("abort_word10", 32'(cnt_out), 32'd10);
    pulse_clr();
    check_val("abort_cnt_out", 32'(cnt_out),    32'h234);
    check_val("abort_idx",     32'(word_idx),   32'd0);
    check_val("abort_done",    32'(rdout_done), 32'd0);
    check_val("abort_busy",    32'(busy),       32'd0);
    pulse_inc();
    check_val("abort_restart", 32'(cnt_out),  32'd1);
    check_val("abort_idx1",    32'(word_idx), 32'd1);

    // clr_rdout in the same cycle as inc_rise, while in SEND
    vsnap = n_valid;
    @(negedge clk50) increment = 1'b1;
    @(negedge clk50);
    @(negedge clk50) clr_rdout = 1'b1;
    @(negedge clk50) clr_rdout = 1'b0;
    check_val("coll_cnt_out", 32'(cnt_out),   32'h234);
    check_val("coll_state",   32'(state_dbg), 32'(ST_IDLE));
    check_val("coll_idx",     32'(word_idx),  32'd0);
    check_val("coll_novalid", 32'(n_valid),   32'(vsnap));
    repeat (2) @(negedge clk50);
    increment = 1'b0;
    repeat (4) @(negedge clk50);
    check_val("coll_still_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Asynchronous reset mid-frame
    repeat (3) pulse_inc();
    check_val("arst_pre", 32'(cnt_out), 32'd3);
    @(posedge clk50);
    #5 rst = 1'b1;
    #1;
    check_val("arst_cnt_out", 32'(cnt_out),   32'h234);
    check_val("arst_idx",     32'(word_idx),  32'd0);
    check_val("arst_busy",    32'(busy),      32'd0);
    check_val("arst_state",   32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk50) rst = 1'b0;
    @(negedge clk50);

    // Bank changes after the first word
    load_bank(1);
    pulse_inc();
    check_val("snap_word0", 32'(cnt_out), 32'd1);
    load_bank(10'h101);
    pulse_inc();
`ifdef CNT_READOUT_SNAPSHOT_EN
    check_val("snap_word1", 32'(cnt_out), 32'd2);
    pulse_inc();
    check_val("snap_word2", 32'(cnt_out), 32'd3);
`else
    check_val("live_word1", 32'(cnt_out), 32'h102);
    pulse_inc();
    check_val("live_word2", 32'(cnt_out), 32'h103);
`endif
    pulse_clr();

    // 16-bit x 4 instance
    pulse_inc2();
    check_val("p_word0", 32'(cnt2), 32'h1111);
    pulse_inc2();
    check_val("p_word1", 32'(cnt2), 32'h2222);
    pulse_inc2();
    check_val("p_word2", 32'(cnt2), 32'h3333);
    pulse_inc2();
    check_val("p_word3", 32'(cnt2), 32'h4444);
    check_val("p_done_lo", 32'(done2), 32'd0);
    check_val("p_idx4",    32'(idx2),  32'd4);
    pulse_inc2();
    check_val("p_trailer", 32'(cnt2),     32'h5A5A);
    check_val("p_done",    32'(done2),    32'd1);
    check_val("p_busy",    32'(busy2),    32'd0);
    check_val("p_valid",   32'(n_valid2), 32'd5);
    check_val("p_overrun", 32'(ovr2),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog bound on total run time
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
